// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared RV32I types for the memory stage
package rv32i_types_pkg;

    typedef enum logic [2:0] {
        MEM_BYTE,
        MEM_HALF,
        MEM_WORD,
        MEM_BYTE_U,
        MEM_HALF_U
    } mem_size_enum;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_R,
        LSU_DONE
    } lsu_state_enum;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input mem_size_enum size, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (size)
            MEM_HALF, MEM_HALF_U: mis = offset[0];
            MEM_WORD:             mis = (offset != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane select and sign/zero extension of a loaded word
module load_extend
    import rv32i_types_pkg::*;
(
    input  logic [31:0]  rdata,
    input  logic [1:0]   offset,
    input  mem_size_enum size,
    output logic [31:0]  data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (offset)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (size)
            MEM_BYTE:   data = {{24{lane_b[7]}}, lane_b};
            MEM_BYTE_U: data = {24'h0, lane_b};
            MEM_HALF:   data = {{16{lane_h[15]}}, lane_h};
            MEM_HALF_U: data = {16'h0, lane_h};
            default:    data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV32I M stage: one data-memory access per instruction over req/gnt/rvalid
module memory_stage
    import rv32i_types_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_M,
    input  logic                  mem_read_M,
    input  logic                  mem_write_M,
    input  mem_size_enum          mem_size_M,
    input  logic [ADDR_WIDTH-1:0] ALU_result_M,
    input  logic [DATA_WIDTH-1:0] write_data_M,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  stall_M,
    output logic [DATA_WIDTH-1:0] load_data_M,
    output logic                  misaligned_M
);

    lsu_state_enum state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            be_q;
    logic                  we_q;
    mem_size_enum          size_q;
    logic [1:0]            offset_q;

    logic                  access;
    logic                  misaligned;
    logic                  aligned_access;
    logic                  capture;
    logic                  in_req;
    logic [3:0]            be_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] ext_data;

    assign access         = valid_M & (mem_read_M | mem_write_M);
    assign misaligned     = access & is_misaligned(mem_size_M, ALU_result_M[1:0]);
    assign aligned_access = access & ~misaligned;

    // Write wins when both read and write are set; loads fetch the whole word.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = '0;
        if (mem_write_M) begin
            case (mem_size_M)
                MEM_BYTE, MEM_BYTE_U: begin
                    be_d    = 4'b0001 << ALU_result_M[1:0];
                    wdata_d = {4{write_data_M[7:0]}};
                end
                MEM_HALF, MEM_HALF_U: begin
                    be_d    = ALU_result_M[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{write_data_M[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = write_data_M;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (aligned_access) begin
                    capture   = 1'b1;
                    state_nxt = LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (dmem_gnt) begin
                    state_nxt = we_q ? LSU_DONE : LSU_WAIT_R;
                end
            end
            LSU_WAIT_R: begin
                if (dmem_rvalid) begin
                    state_nxt = LSU_DONE;
                end
            end
            default: begin
                state_nxt = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LSU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            size_q   <= MEM_BYTE;
            offset_q <= 2'b00;
        end else if (capture) begin
            addr_q   <= {ALU_result_M[ADDR_WIDTH-1:2], 2'b00};
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            we_q     <= mem_write_M;
            size_q   <= mem_size_M;
            offset_q <= ALU_result_M[1:0];
        end
    end

    load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .offset (offset_q),
        .size   (size_q),
        .data   (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data_M <= '0;
        end else if (state == LSU_WAIT_R && dmem_rvalid) begin
            load_data_M <= ext_data;
        end
    end

    // Bus fields are only presented while requesting, so reset clears them at once.
    assign in_req     = (state == LSU_REQ);
    assign dmem_req   = in_req;
    assign dmem_we    = in_req & we_q;
    assign dmem_addr  = in_req ? addr_q : '0;
    assign dmem_wdata = in_req ? wdata_q : '0;
    assign dmem_be    = in_req ? be_q : 4'b0000;

    assign stall_M      = rst_n & aligned_access & (state != LSU_DONE);
    assign misaligned_M = rst_n & misaligned;

    a_rd_wr_exclusive : assert property (
        @(posedge clk) disable iff (!rst_n) !(valid_M && mem_read_M && mem_write_M)
    );

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage
module tb_memory_stage;
    import rv32i_types_pkg::*;

    typedef struct {
        logic         ld;
        mem_size_enum size;
        logic [31:0]  addr;
        logic [31:0]  wd;
        logic [31:0]  rdata;
        int           gnt_dly;
        int           rv_wait;
        logic         exp_mis;
        logic [3:0]   exp_be;
        logic [31:0]  exp_addr;
        logic [31:0]  exp_wdata;
        logic [31:0]  exp_load;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_M, mem_read_M, mem_write_M;
    mem_size_enum mem_size_M;
    logic [31:0]  ALU_result_M, write_data_M;
    logic         dmem_req, dmem_we;
    logic [31:0]  dmem_addr, dmem_wdata;
    logic [3:0]   dmem_be;
    logic         dmem_gnt, dmem_rvalid;
    logic [31:0]  dmem_rdata;
    logic         stall_M;
    logic [31:0]  load_data_M;
    logic         misaligned_M;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t exp_q[$];
    vec_t vecs[14];

    memory_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_M      (valid_M),
        .mem_read_M   (mem_read_M),
        .mem_write_M  (mem_write_M),
        .mem_size_M   (mem_size_M),
        .ALU_result_M (ALU_result_M),
        .write_data_M (write_data_M),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .stall_M      (stall_M),
        .load_data_M  (load_data_M),
        .misaligned_M (misaligned_M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t        e;
        logic [3:0]  be0;
        logic [31:0] a0, w0;
        logic        we0;
        bit          seen, granted, stable, done, quiet;
        int          reqc, waitc, cyc, exp_cyc;
        @(negedge clk);
        valid_M      = 1'b1;
        mem_read_M   = v.ld;
        mem_write_M  = ~v.ld;
        mem_size_M   = v.size;
        ALU_result_M = v.addr;
        write_data_M = v.wd;
        exp_q.push_back(v);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("v%0d misaligned", idx), {31'h0, misaligned_M}, {31'h0, e.exp_mis});
        if (e.exp_mis) begin
            quiet = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (dmem_req !== 1'b0 || stall_M !== 1'b0) quiet = 1'b0;
                @(negedge clk);
                #1;
            end
            chk($sformatf("v%0d misaligned quiet", idx), {31'h0, quiet}, 32'h1);
            chk($sformatf("v%0d load_data", idx), load_data_M, e.exp_load);
            return;
        end
        seen = 0; granted = 0; stable = 1; done = 0;
        reqc = 0; waitc = 0; cyc = 0;
        be0 = '0; a0 = '0; w0 = '0; we0 = 1'b0;
        while (!done && cyc < 50) begin
            cyc++;
            if (dmem_req) begin
                if (!seen) begin
                    seen = 1; be0 = dmem_be; a0 = dmem_addr; w0 = dmem_wdata; we0 = dmem_we;
                end else if (dmem_be !== be0 || dmem_addr !== a0 || dmem_wdata !== w0 || dmem_we !== we0) begin
                    stable = 0;
                end
                if (e.ld) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = 32'hBAD0BAD0;
                end
                if (reqc == e.gnt_dly) begin
                    dmem_gnt = 1'b1;
                    granted  = 1;
                end
                reqc++;
            end else if (granted && e.ld) begin
                if (waitc == e.rv_wait) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = e.rdata;
                end
                waitc++;
            end
            if (!stall_M) begin
                done = 1;
            end else begin
                @(negedge clk);
                dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
                #1;
            end
        end
        exp_cyc = e.ld ? (4 + e.gnt_dly + e.rv_wait) : (3 + e.gnt_dly);
        chk($sformatf("v%0d completed", idx), {31'h0, done}, 32'h1);
        chk($sformatf("v%0d occupancy", idx), cyc, exp_cyc);
        chk($sformatf("v%0d be", idx), {28'h0, be0}, {28'h0, e.exp_be});
        chk($sformatf("v%0d addr", idx), a0, e.exp_addr);
        chk($sformatf("v%0d we", idx), {31'h0, we0}, {31'h0, ~e.ld});
        if (!e.ld) chk($sformatf("v%0d wdata", idx), w0, e.exp_wdata);
        chk($sformatf("v%0d req stable", idx), {31'h0, stable}, 32'h1);
        chk($sformatf("v%0d load_data", idx), load_data_M, e.exp_load);
    endtask

    task automatic idle_check(input string name);
        bit quiet;
        quiet = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (dmem_req !== 1'b0 || stall_M !== 1'b0 || misaligned_M !== 1'b0) quiet = 1'b0;
        end
        chk(name, {31'h0, quiet}, 32'h1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, MEM_WORD,   32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 1'b0, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, MEM_BYTE,   32'h103, 32'h000000A5, 32'h0,        0, 0, 1'b0, 4'h8, 32'h100, 32'hA5A5A5A5, 32'h0};
        vecs[2]  = '{1'b1, MEM_BYTE,   32'h102, 32'h0,        32'h0080FF00, 2, 2, 1'b0, 4'hF, 32'h100, 32'h0,        32'hFFFFFF80};
        vecs[3]  = '{1'b1, MEM_HALF_U, 32'h102, 32'h0,        32'h80011234, 0, 0, 1'b0, 4'hF, 32'h100, 32'h0,        32'h00008001};
        vecs[4]  = '{1'b1, MEM_WORD,   32'h101, 32'h0,        32'h0,        0, 0, 1'b1, 4'h0, 32'h0,   32'h0,        32'h00008001};
        vecs[5]  = '{1'b0, MEM_HALF,   32'h102, 32'h1234BEEF, 32'h0,        1, 0, 1'b0, 4'hC, 32'h100, 32'hBEEFBEEF, 32'h00008001};
        vecs[6]  = '{1'b1, MEM_HALF,   32'h100, 32'h0,        32'h0000F00D, 0, 1, 1'b0, 4'hF, 32'h100, 32'h0,        32'hFFFFF00D};
        vecs[7]  = '{1'b1, MEM_BYTE_U, 32'h201, 32'h0,        32'h000080FF, 1, 0, 1'b0, 4'hF, 32'h200, 32'h0,        32'h00000080};
        vecs[8]  = '{1'b0, MEM_HALF,   32'h101, 32'h00005555, 32'h0,        0, 0, 1'b1, 4'h0, 32'h0,   32'h0,        32'h00000080};
        vecs[9]  = '{1'b1, MEM_WORD,   32'h304, 32'h0,        32'hCAFEF00D, 0, 1, 1'b0, 4'hF, 32'h304, 32'h0,        32'hCAFEF00D};
        vecs[10] = '{1'b0, MEM_BYTE,   32'h301, 32'h12345677, 32'h0,        0, 0, 1'b0, 4'h2, 32'h300, 32'h77777777, 32'hCAFEF00D};
        vecs[11] = '{1'b1, MEM_BYTE,   32'h303, 32'h0,        32'h7F000000, 0, 0, 1'b0, 4'hF, 32'h300, 32'h0,        32'h0000007F};
        vecs[12] = '{1'b1, MEM_HALF,   32'h102, 32'h0,        32'h80011234, 0, 0, 1'b0, 4'hF, 32'h100, 32'h0,        32'hFFFF8001};
        vecs[13] = '{1'b1, MEM_WORD,   32'h102, 32'h0,        32'h0,        0, 0, 1'b1, 4'h0, 32'h0,   32'h0,        32'hFFFF8001};

        rst_n = 1'b0;
        valid_M = 1'b0; mem_read_M = 1'b0; mem_write_M = 1'b0; mem_size_M = MEM_WORD;
        ALU_result_M = '0; write_data_M = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset req", {31'h0, dmem_req}, 32'h0);
        chk("reset stall", {31'h0, stall_M}, 32'h0);
        chk("reset load_data", load_data_M, 32'h0);
        chk("reset be", {28'h0, dmem_be}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        @(negedge clk);
        valid_M = 1'b0; mem_read_M = 1'b1; mem_write_M = 1'b0; mem_size_M = MEM_WORD; ALU_result_M = 32'h101;
        idle_check("bubble quiet");
        @(negedge clk);
        valid_M = 1'b1; mem_read_M = 1'b0; mem_write_M = 1'b0;
        idle_check("non-mem quiet");

        // Reset while waiting for read data.
        @(negedge clk);
        valid_M = 1'b1; mem_read_M = 1'b1; mem_size_M = MEM_WORD; ALU_result_M = 32'h400;
        @(negedge clk);
        #1;
        chk("rst seq req", {31'h0, dmem_req}, 32'h1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        chk("rst seq wait_r stall", {31'h0, stall_M}, 32'h1);
        chk("rst seq wait_r req", {31'h0, dmem_req}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async stall", {31'h0, stall_M}, 32'h0);
        chk("rst async load_data", load_data_M, 32'h0);
        @(negedge clk);
        valid_M = 1'b0; mem_read_M = 1'b0;
        rst_n = 1'b1;
        idle_check("post-reset idle");
        chk("post-reset load_data", load_data_M, 32'h0);
        run_vec('{1'b1, MEM_WORD, 32'h500, 32'h0, 32'h13579BDF, 0, 0, 1'b0, 4'hF, 32'h500, 32'h0, 32'h13579BDF}, 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
